snes_poller: RTL and testbench
==============================

# snes_poller

- Self-contained SNES controller reader, upstream of the control FSM.
- Divides the system clock into the SNES bit clock and issues latch and clock pulses at a fixed poll rate.
- Shifts in 16 serial bits per poll and publishes 12 active-high button states that the FSM consumes directly.
- Also reports frame validity so software-visible button state never holds a corrupted frame.

## Interface
- CLK_DIV, 300: clk cycles per tick; one tick is half an SNES clock period (6 µs at 50 MHz).
- POLL_CYCLES, 833333: clk cycles between poll requests (60 Hz at 50 MHz); must exceed 34·CLK_DIV+2.
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- serial_data  in  1  controller data line; active-low button data.
- snes_clk  out  1  controller clock; idles high.
- data_latch  out  1  controller latch; active-high.
- button_data  out  12  active-high buttons: [0]B [1]Y [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right [8]A [9]X [10]L [11]R.
- buttons_valid  out  1  one-clk pulse when a good frame completes.
- frame_err  out  1  one-clk pulse when a frame is rejected.

## Operation
- **Tick counter.** Counts 0..CLK_DIV-1 and wraps. `tick` is asserted in the cycle where the count equals CLK_DIV-1.
- **Poll counter.** Free-running 20-bit counter, 0..POLL_CYCLES-1.
  - Reaching POLL_CYCLES-1 sets a `pending` flag.
  - If a request arrives while not IDLE, `pending` stays set and is serviced on the next return to IDLE. Requests never queue deeper than one.
- **FSM states:** IDLE, LATCH, SHIFT_LO, SHIFT_HI, DONE.
  - IDLE: if `pending` and `tick`, clear `pending` and go to LATCH.
  - LATCH: data_latch=1 for 2 ticks, then go to SHIFT_LO with bit index 0.
  - SHIFT_LO: snes_clk=0 for 1 tick. serial_data is sampled into shift[idx] on the clk edge that enters SHIFT_LO. Next state is SHIFT_HI.
  - SHIFT_HI: snes_clk=1 for 1 tick. If idx==15, go to DONE; otherwise increment idx and go to SHIFT_LO.
  - DONE: lasts 1 clk cycle, then returns to IDLE.
- **Frame check in DONE.** The frame is good when raw bits 12..15 all read 1 (unused bits idle high).
  - Good frame: button_data = ~raw[11:0] and buttons_valid pulses.
  - Bad frame: button_data holds its value and frame_err pulses.
- A disconnected controller (line pulled high) yields a good frame with all buttons released.
- idx is 4 bits and never wraps past 15. The shift register is 16 bits.

## Timing
- Reset values: snes_clk=1, data_latch=0, button_data=0, buttons_valid=0, frame_err=0, FSM=IDLE, both counters=0, pending=0.
- Reset asserted mid-frame returns all outputs to reset values asynchronously. The partial frame is discarded and the next poll restarts from LATCH.
- Frame length from LATCH entry to DONE: 34 ticks (2 latch + 32 shift).
- buttons_valid or frame_err asserts 1 clk cycle after the final SHIFT_HI tick.
- Bit n is sampled (2+2n)·CLK_DIV clk cycles after LATCH entry.
- All outputs are registered; there are no combinational paths from serial_data to any output.
- button_data changes only in the DONE cycle.

## Configuration
- Macro: SNES_DEBOUNCE_EN.
- **Defined:**
  - A 12-bit register holds the last good frame.
  - button_data updates only when the current good frame equals that stored frame; the stored frame is then refreshed.
  - buttons_valid pulses on every good frame.
  - frame_err frames do not touch the stored frame.
  - Reset clears the stored frame to 0.
- **Undefined:** every good frame updates button_data immediately. The stored-frame register is absent.

## Test plan
- Reset: hold reset 5 cycles, then release → snes_clk=1, data_latch=0, button_data=12'h000, no pulses until the first poll.
- CLK_DIV=4, POLL_CYCLES=200 → data_latch high exactly 8 clks, then 16 snes_clk low/high pairs of 4 clks each; next latch 200 clks after the previous request.
- Drive raw bits 0 and 3 low, all others high → button_data=12'h009 with one buttons_valid pulse. Without the macro it updates on frame 1; with SNES_DEBOUNCE_EN it updates on frame 2.
- Drive bit 13 low with buttons otherwise released, after a prior 12'h009 frame → frame_err pulses once and button_data stays 12'h009.
- Assert reset during SHIFT_LO of bit 7 → outputs at reset values within the same cycle; the next frame after release decodes correctly.
- Hold serial_data at 1 constantly → every frame is good with button_data=12'h000 and a buttons_valid pulse each poll.

Source files
------------

// File: rtl/snes_poller.sv
// SNES controller poller: generates latch/clock, shifts in 16 bits, publishes 12 buttons.
// Optional SNES_DEBOUNCE_EN: publish a good frame only when it matches the previous good frame.
module snes_poller #(
  parameter int CLK_DIV     = 300,
  parameter int POLL_CYCLES = 833333
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        serial_data,
  output logic        snes_clk,
  output logic        data_latch,
  output logic [11:0] button_data,
  output logic        buttons_valid,
  output logic        frame_err
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, LATCH, SHIFT_LO, SHIFT_HI, DONE} state_t;

  state_t        state, state_nx;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [19:0]   poll_cnt;
  logic          poll_req;
  logic          pending;
  logic          start;
  logic          lat_half, lat_half_nx;
  logic [3:0]    idx, idx_nx;
  logic [15:0]   shift;
  logic          sample;
  logic          frame_done;
  logic          good;
  logic [11:0]   frame_btn;

  assign tick      = (tick_cnt == TW'(CLK_DIV - 1));
  assign poll_req  = (poll_cnt == 20'(POLL_CYCLES - 1));
  assign good      = &shift[15:12];
  assign frame_btn = ~shift[11:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      poll_cnt <= '0;
      pending  <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      poll_cnt <= poll_req ? '0 : poll_cnt + 1'b1;
      if (poll_req)
        pending <= 1'b1;
      else if (start)
        pending <= 1'b0;
    end
  end

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    lat_half_nx = lat_half;
    sample      = 1'b0;
    frame_done  = 1'b0;
    start       = 1'b0;
    case (state)
      IDLE: begin
        if (pending && tick) begin
          start       = 1'b1;
          state_nx    = LATCH;
          lat_half_nx = 1'b0;
        end
      end
      LATCH: begin
        if (tick) begin
          if (lat_half) begin
            state_nx = SHIFT_LO;
            idx_nx   = '0;
            sample   = 1'b1;
          end else begin
            lat_half_nx = 1'b1;
          end
        end
      end
      SHIFT_LO: begin
        if (tick) state_nx = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (tick) begin
          if (idx == 4'd15) begin
            state_nx   = DONE;
            frame_done = 1'b1;
          end else begin
            idx_nx   = idx + 1'b1;
            state_nx = SHIFT_LO;
            sample   = 1'b1;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up exactly with the
  // state they describe; the frame verdict lands in the DONE cycle itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      lat_half      <= 1'b0;
      shift         <= '0;
      snes_clk      <= 1'b1;
      data_latch    <= 1'b0;
      buttons_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      state         <= state_nx;
      idx           <= idx_nx;
      lat_half      <= lat_half_nx;
      if (sample) shift[idx_nx] <= serial_data;
      snes_clk      <= (state_nx != SHIFT_LO);
      data_latch    <= (state_nx == LATCH);
      buttons_valid <= frame_done && good;
      frame_err     <= frame_done && !good;
    end
  end

`ifdef SNES_DEBOUNCE_EN
  logic [11:0] last_good;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      button_data <= '0;
      last_good   <= '0;
    end else if (frame_done && good) begin
      if (frame_btn == last_good) button_data <= frame_btn;
      last_good <= frame_btn;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      button_data <= '0;
    else if (frame_done && good)
      button_data <= frame_btn;
  end
`endif

endmodule

// File: tb/tb_snes_poller.sv
// Randomized bench for snes_poller against a timing/frame model derived from poll arithmetic.
module tb_snes_poller;

  localparam int CD = 4;
  localparam int P  = 200;
  localparam int FL = 34 * CD;

`ifdef SNES_DEBOUNCE_EN
  localparam logic [11:0] PIN_F1 = 12'h000;
`else
  localparam logic [11:0] PIN_F1 = 12'h009;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        serial_data = 1'b1;
  logic        snes_clk;
  logic        data_latch;
  logic [11:0] button_data;
  logic        buttons_valid;
  logic        frame_err;

  snes_poller #(.CLK_DIV(CD), .POLL_CYCLES(P)) dut (
    .clk          (clk),
    .reset        (reset),
    .serial_data  (serial_data),
    .snes_clk     (snes_clk),
    .data_latch   (data_latch),
    .button_data  (button_data),
    .buttons_valid(buttons_valid),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int          t = 0;
  int          base = 0;
  int          compared = 0;
  int          mismatched = 0;
  bit          hold_high = 1'b0;
  logic [15:0] raw_tab [0:31];
  logic [11:0] exp_b = '0;
  logic [11:0] stored = '0;

  // Latch entry of poll k: first multiple of CD strictly after the k-th request.
  function automatic int lstart(input int k);
    return (k * P / CD + 1) * CD;
  endfunction

  function automatic void locate(input int tt, output int k, output int rel);
    k = 0;
    rel = 0;
    for (int j = 1; lstart(j) <= tt; j++) k = j;
    if (k > 0) rel = tt - lstart(k);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s t=%0d got=%0h want=%0h", name, t, act, exp);
    end
  endtask

  always @(posedge clk or posedge reset) begin : cmp
    int k, rel, g;
    logic [15:0] raw;
    logic inf, good, e_lat, e_sclk, e_v, e_e;
    #1;
    if (reset) begin
      locate(t, k, rel);
      base   = base + k;
      t      = 0;
      exp_b  = '0;
      stored = '0;
      chk("rst_snes_clk", 32'(snes_clk), 32'(1));
      chk("rst_data_latch", 32'(data_latch), 32'(0));
      chk("rst_buttons", 32'(button_data), 32'(0));
      chk("rst_valid", 32'(buttons_valid), 32'(0));
      chk("rst_err", 32'(frame_err), 32'(0));
    end else begin
      t = t + 1;
      locate(t, k, rel);
      g      = base + k;
      inf    = (k > 0) && (rel <= FL);
      e_lat  = inf && (rel < 2 * CD);
      e_sclk = !(inf && rel >= 2 * CD && rel < FL && ((rel - 2 * CD) / CD) % 2 == 0);
      e_v    = 1'b0;
      e_e    = 1'b0;
      if (inf && rel == FL) begin
        raw  = raw_tab[g];
        good = (raw[15:12] == 4'hF);
        e_v  = good;
        e_e  = !good;
        if (good) begin
`ifdef SNES_DEBOUNCE_EN
          if (~raw[11:0] == stored) exp_b = ~raw[11:0];
          stored = ~raw[11:0];
`else
          exp_b = ~raw[11:0];
`endif
        end
      end
      chk("snes_clk", 32'(snes_clk), 32'(e_sclk));
      chk("data_latch", 32'(data_latch), 32'(e_lat));
      chk("button_data", 32'(button_data), 32'(exp_b));
      chk("buttons_valid", 32'(buttons_valid), 32'(e_v));
      chk("frame_err", 32'(frame_err), 32'(e_e));
      if (base == 0) begin
        if (t == 203) chk("pin_latch_pre", 32'(data_latch), 32'(0));
        if (t == 204) chk("pin_latch_rise", 32'(data_latch), 32'(1));
        if (t == 211) chk("pin_latch_last", 32'(data_latch), 32'(1));
        if (t == 212) chk("pin_latch_fall", 32'(data_latch), 32'(0));
        if (t == 212) chk("pin_sclk_low", 32'(snes_clk), 32'(0));
        if (t == 216) chk("pin_sclk_high", 32'(snes_clk), 32'(1));
      end
      if (inf && rel == FL) begin
        case (g)
          1: chk("pin_frame1_buttons", 32'(button_data), 32'(PIN_F1));
          2: chk("pin_frame2_buttons", 32'(button_data), 32'(12'h009));
          3: begin
            chk("pin_frame3_err", 32'(frame_err), 32'(1));
            chk("pin_frame3_buttons", 32'(button_data), 32'(12'h009));
          end
          12: chk("pin_post_reset_buttons", 32'(button_data), 32'(12'h009));
          26: begin
            chk("pin_idle_high_buttons", 32'(button_data), 32'(12'h000));
            chk("pin_idle_high_valid", 32'(buttons_valid), 32'(1));
          end
          default: ;
        endcase
      end
    end
  end

  // Serial line: frame bit n held across its whole low/high window, junk elsewhere.
  initial begin : drv_serial
    int k, r;
    logic [15:0] raw;
    forever begin
      @(negedge clk);
      if (hold_high) begin
        serial_data = 1'b1;
      end else begin
        locate(t + 1, k, r);
        if (!reset && k > 0 && r >= 2 * CD && r < FL) begin
          raw = raw_tab[base + k];
          serial_data = raw[4'((r - 2 * CD) / (2 * CD))];
        end else begin
          serial_data = 1'($urandom);
        end
      end
    end
  end

  task automatic wait_t(input int tt);
    int n = 0;
    while (t < tt) begin
      @(negedge clk);
      n++;
      if (n > 20000) begin
        $display("FAIL wait_t got_t=%0d want_t=%0d", t, tt);
        $fatal(1, "cycle budget exhausted");
      end
    end
  endtask

  initial begin : main
    logic [15:0] v;
    for (int g = 0; g < 32; g++) begin
      if (g >= 4 && g % 2 == 0 && $urandom_range(0, 1) == 1) begin
        raw_tab[g] = raw_tab[g - 1];
      end else if ($urandom_range(0, 3) != 0) begin
        raw_tab[g] = {4'hF, 12'($urandom)};
      end else begin
        v = 16'($urandom);
        v[12 + $urandom_range(0, 3)] = 1'b0;
        raw_tab[g] = v;
      end
    end
    raw_tab[0]  = 16'hFFFF;
    raw_tab[1]  = 16'hFFF6;
    raw_tab[2]  = 16'hFFF6;
    raw_tab[3]  = 16'hDFFF;
    raw_tab[11] = 16'hFFF6;
    raw_tab[12] = 16'hFFF6;
    for (int g = 21; g < 32; g++) raw_tab[g] = 16'hFFFF;

    #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Reset lands inside SHIFT_LO of bit 7 of poll 10.
    wait_t(lstart(10) + 16 * CD + 1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    wait_t(lstart(10) + FL + 5);
    hold_high = 1'b1;
    wait_t(lstart(16) + FL + 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
